// File: rtl/psram_arb_pkg.sv
// Shared definitions for the PSRAM command arbiter: state encoding,
// command encoding and bus widths.
package psram_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_WDAT = 2'd2;
    localparam logic [1:0] ST_RDAT = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CMD  = ST_CMD,
        WDAT = ST_WDAT,
        RDAT = ST_RDAT
    } state_t;

    localparam logic PS_CMD_WRITE = 1'b1;
    localparam logic PS_CMD_READ  = 1'b0;

    localparam int PS_ADDR_W = 23;
    localparam int PS_DATA_W = 32;
    localparam int PS_MASK_W = 4;

endpackage

// File: rtl/psram_cmd_arb_if.sv
// Bundle of both master ports and the PSRAM controller port.
// slave = arbiter view, master = the agents driving masters and the controller.
interface psram_cmd_arb_if;
    import psram_arb_pkg::*;

    logic                 m0_cmd_en;
    logic                 m0_cmd;
    logic [PS_ADDR_W-1:0] m0_addr;
    logic [PS_DATA_W-1:0] m0_wdata;
    logic [PS_MASK_W-1:0] m0_mask;
    logic                 m0_ready;
    logic                 m0_rvalid;
    logic                 m0_wbeat;

    logic                 m1_cmd_en;
    logic                 m1_cmd;
    logic [PS_ADDR_W-1:0] m1_addr;
    logic [PS_DATA_W-1:0] m1_wdata;
    logic [PS_MASK_W-1:0] m1_mask;
    logic                 m1_ready;
    logic                 m1_rvalid;
    logic                 m1_wbeat;

    logic [PS_DATA_W-1:0] m_rdata;

    logic                 psram_cmd;
    logic                 psram_cmd_en;
    logic [PS_ADDR_W-1:0] psram_addr;
    logic [PS_DATA_W-1:0] psram_wdata;
    logic [PS_MASK_W-1:0] psram_mask;
    logic                 psram_ready;
    logic                 psram_rvalid;
    logic [PS_DATA_W-1:0] psram_rdata;

    logic [1:0]           grant;
    logic                 busy;
    logic                 err_stray;

    modport slave (
        input  m0_cmd_en, m0_cmd, m0_addr, m0_wdata, m0_mask,
        output m0_ready, m0_rvalid, m0_wbeat,
        input  m1_cmd_en, m1_cmd, m1_addr, m1_wdata, m1_mask,
        output m1_ready, m1_rvalid, m1_wbeat,
        output m_rdata,
        output psram_cmd, psram_cmd_en, psram_addr, psram_wdata, psram_mask,
        input  psram_ready, psram_rvalid, psram_rdata,
        output grant, busy, err_stray
    );

    modport master (
        output m0_cmd_en, m0_cmd, m0_addr, m0_wdata, m0_mask,
        input  m0_ready, m0_rvalid, m0_wbeat,
        output m1_cmd_en, m1_cmd, m1_addr, m1_wdata, m1_mask,
        input  m1_ready, m1_rvalid, m1_wbeat,
        input  m_rdata,
        input  psram_cmd, psram_cmd_en, psram_addr, psram_wdata, psram_mask,
        output psram_ready, psram_rvalid, psram_rdata,
        input  grant, busy, err_stray
    );

endinterface

// File: rtl/psram_arb_pick.sv
// Two-request picker producing a one-hot winner. PSARB_ROUND_ROBIN_EN
// selects round-robin tie-breaking; otherwise master 0 always wins ties.
module psram_arb_pick (
    input  logic [1:0] i_req,
    input  logic       i_last_owner,
    output logic [1:0] o_pick
);

`ifdef PSARB_ROUND_ROBIN_EN
    // On a tie, grant whichever master did not own the port last.
    always_comb begin
        o_pick = 2'b00;
        if (i_req == 2'b11) begin
            o_pick = i_last_owner ? 2'b01 : 2'b10;
        end else if (i_req[0]) begin
            o_pick = 2'b01;
        end else if (i_req[1]) begin
            o_pick = 2'b10;
        end else begin
            o_pick = 2'b00;
        end
    end
`else
    logic w_unused_last_owner;
    assign w_unused_last_owner = i_last_owner;

    // Fixed priority: master 0 first.
    always_comb begin
        o_pick = 2'b00;
        if (i_req[0]) begin
            o_pick = 2'b01;
        end else if (i_req[1]) begin
            o_pick = 2'b10;
        end else begin
            o_pick = 2'b00;
        end
    end
`endif

endmodule

// File: rtl/psram_cmd_arb.sv
// Shares one PSRAM command/data port between two burst masters, holding
// ownership for a full burst. Optional macro: PSARB_ROUND_ROBIN_EN.
module psram_cmd_arb
    import psram_arb_pkg::*;
#(
    parameter int BURST_WORDS = 16,
    parameter int CNT_W       = 4
) (
    input  logic           psclk,
    input  logic           PSRST,
    psram_cmd_arb_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

    state_t           r_state, w_state_nx;
    logic [1:0]       r_grant, w_grant_nx;
    logic             r_cur_cmd, w_cur_cmd_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic             r_owner, w_owner_nx;
    logic             r_has_owner, w_has_owner_nx;

    logic [1:0] w_req;
    logic [1:0] w_pick;
    logic       w_own_en;
    logic       w_accept;
    logic       w_wbeat;
    logic       w_rbeat;

    assign w_req = {bus.m1_cmd_en, bus.m0_cmd_en};

    psram_arb_pick u_pick (
        .i_req        (w_req),
        .i_last_owner (r_owner),
        .o_pick       (w_pick)
    );

    assign w_own_en = r_owner ? bus.m1_cmd_en : bus.m0_cmd_en;
    assign w_accept = (r_state == CMD) & w_own_en & bus.psram_ready;
    assign w_wbeat  = (w_accept & (r_cur_cmd == PS_CMD_WRITE)) | (r_state == WDAT);
    assign w_rbeat  = (r_state == RDAT) & bus.psram_rvalid;

    // Data path follows the most recent owner; zero until the first grant.
    assign bus.psram_cmd_en = (r_state == CMD) & w_own_en;
    assign bus.psram_cmd    = r_has_owner & (r_owner ? bus.m1_cmd : bus.m0_cmd);
    assign bus.psram_addr   = r_has_owner ? (r_owner ? bus.m1_addr : bus.m0_addr)
                                          : {PS_ADDR_W{1'b0}};
    assign bus.psram_wdata  = r_has_owner ? (r_owner ? bus.m1_wdata : bus.m0_wdata)
                                          : {PS_DATA_W{1'b0}};
    assign bus.psram_mask   = r_has_owner ? (r_owner ? bus.m1_mask : bus.m0_mask)
                                          : {PS_MASK_W{1'b0}};

    assign bus.m0_ready  = w_accept & ~r_owner;
    assign bus.m1_ready  = w_accept &  r_owner;
    assign bus.m0_wbeat  = w_wbeat  & ~r_owner;
    assign bus.m1_wbeat  = w_wbeat  &  r_owner;
    assign bus.m0_rvalid = w_rbeat  & ~r_owner;
    assign bus.m1_rvalid = w_rbeat  &  r_owner;
    assign bus.m_rdata   = bus.psram_rdata;
    assign bus.grant     = r_grant;
    assign bus.busy      = (r_state != IDLE);
    assign bus.err_stray = bus.psram_rvalid & (r_state != RDAT) & ~PSRST;

    // Arbitration and burst sequencing.
    always_comb begin
        w_state_nx     = r_state;
        w_grant_nx     = r_grant;
        w_cur_cmd_nx   = r_cur_cmd;
        w_cnt_nx       = r_cnt;
        w_owner_nx     = r_owner;
        w_has_owner_nx = r_has_owner;
        case (r_state)
            IDLE: begin
                if (w_pick != 2'b00) begin
                    w_state_nx     = CMD;
                    w_grant_nx     = w_pick;
                    w_owner_nx     = w_pick[1];
                    w_has_owner_nx = 1'b1;
                    w_cur_cmd_nx   = w_pick[1] ? bus.m1_cmd : bus.m0_cmd;
                end else begin
                    w_state_nx = IDLE;
                end
            end
            CMD: begin
                if (!w_own_en) begin
                    w_state_nx = IDLE;
                    w_grant_nx = 2'b00;
                end else if (bus.psram_ready) begin
                    if (r_cur_cmd == PS_CMD_WRITE) begin
                        w_state_nx = WDAT;
                        w_cnt_nx   = CNT_ONE;
                    end else begin
                        w_state_nx = RDAT;
                        w_cnt_nx   = CNT_ZERO;
                    end
                end else begin
                    w_state_nx = CMD;
                end
            end
            WDAT: begin
                if (r_cnt == LAST_BEAT) begin
                    w_state_nx = IDLE;
                    w_grant_nx = 2'b00;
                    w_cnt_nx   = CNT_ZERO;
                end else begin
                    w_cnt_nx = r_cnt + CNT_ONE;
                end
            end
            RDAT: begin
                if (bus.psram_rvalid) begin
                    if (r_cnt == LAST_BEAT) begin
                        w_state_nx = IDLE;
                        w_grant_nx = 2'b00;
                        w_cnt_nx   = CNT_ZERO;
                    end else begin
                        w_cnt_nx = r_cnt + CNT_ONE;
                    end
                end else begin
                    w_state_nx = RDAT;
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_grant_nx = 2'b00;
                w_cnt_nx   = CNT_ZERO;
            end
        endcase
    end

    // State registers; owner resets to master 1 so master 0 wins the first tie.
    always_ff @(posedge psclk or posedge PSRST) begin
        if (PSRST) begin
            r_state     <= IDLE;
            r_grant     <= 2'b00;
            r_cur_cmd   <= PS_CMD_READ;
            r_cnt       <= CNT_ZERO;
            r_owner     <= 1'b1;
            r_has_owner <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_grant     <= w_grant_nx;
            r_cur_cmd   <= w_cur_cmd_nx;
            r_cnt       <= w_cnt_nx;
            r_owner     <= w_owner_nx;
            r_has_owner <= w_has_owner_nx;
        end
    end

endmodule

// File: tb/tb_psram_cmd_arb.sv
// Self-checking bench for psram_cmd_arb: directed test-plan steps followed by
// randomized traffic, all checked cycle by cycle against a burst-level model.
module tb_psram_cmd_arb;

    localparam int BW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    psram_cmd_arb_if bus ();

    psram_cmd_arb #(.BURST_WORDS(BW), .CNT_W(4)) dut (
        .psclk (clk),
        .PSRST (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: phase 0 idle, 1 command offered, 2 write data, 3 read data.
    int ph;
    int own;
    int beats;
    bit lcmd;

    int ready_cnt[2];
    int rvalid_cnt[2];
    int wbeat_cnt[2];
    int grant_log[$];
    logic [1:0] prev_grant = 2'b00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ph = 0; own = 1; beats = 0; lcmd = 1'b0;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 2; i++) begin
            ready_cnt[i] = 0; rvalid_cnt[i] = 0; wbeat_cnt[i] = 0;
        end
    endtask

    task automatic idle_inputs();
        bus.m0_cmd_en = 1'b0; bus.m1_cmd_en = 1'b0;
        bus.psram_ready = 1'b0; bus.psram_rvalid = 1'b0; bus.psram_rdata = 32'd0;
    endtask

    // One clock: check outputs at the falling edge, advance the model at the rising edge.
    task automatic step();
        bit e0, e1, eo, acc, wb, rv;
        int nph, nown, nbeats, p;
        bit nlcmd;
        @(negedge clk);
        if (rst) model_reset();
        e0 = bus.m0_cmd_en; e1 = bus.m1_cmd_en;
        eo = (own == 1) ? e1 : e0;
        acc = (ph == 1) && eo && bus.psram_ready;
        wb  = (acc && lcmd) || (ph == 2);
        rv  = (ph == 3) && bus.psram_rvalid;
        chk("grant", 32'(bus.grant), (ph == 0) ? 32'd0 : ((own == 1) ? 32'd2 : 32'd1));
        chk("busy", 32'(bus.busy), 32'(ph != 0));
        chk("psram_cmd_en", 32'(bus.psram_cmd_en), 32'((ph == 1) && eo));
        chk("m0_ready", 32'(bus.m0_ready), 32'(acc && own == 0));
        chk("m1_ready", 32'(bus.m1_ready), 32'(acc && own == 1));
        chk("m0_wbeat", 32'(bus.m0_wbeat), 32'(wb && own == 0));
        chk("m1_wbeat", 32'(bus.m1_wbeat), 32'(wb && own == 1));
        chk("m0_rvalid", 32'(bus.m0_rvalid), 32'(rv && own == 0));
        chk("m1_rvalid", 32'(bus.m1_rvalid), 32'(rv && own == 1));
        chk("err_stray", 32'(bus.err_stray), 32'(bus.psram_rvalid && ph != 3 && !rst));
        chk("m_rdata", bus.m_rdata, bus.psram_rdata);
        if (ph == 1) begin
            chk("psram_addr", 32'(bus.psram_addr), 32'((own == 1) ? bus.m1_addr : bus.m0_addr));
            chk("psram_cmd", 32'(bus.psram_cmd), 32'((own == 1) ? bus.m1_cmd : bus.m0_cmd));
        end
        if (ph == 1 || ph == 2) begin
            chk("psram_wdata", bus.psram_wdata, (own == 1) ? bus.m1_wdata : bus.m0_wdata);
            chk("psram_mask", 32'(bus.psram_mask), 32'((own == 1) ? bus.m1_mask : bus.m0_mask));
        end
        ready_cnt[0] += int'(bus.m0_ready);  ready_cnt[1] += int'(bus.m1_ready);
        rvalid_cnt[0] += int'(bus.m0_rvalid); rvalid_cnt[1] += int'(bus.m1_rvalid);
        wbeat_cnt[0] += int'(bus.m0_wbeat);  wbeat_cnt[1] += int'(bus.m1_wbeat);
        if (bus.grant != 2'b00 && prev_grant == 2'b00) grant_log.push_back(int'(bus.grant[1]));
        prev_grant = bus.grant;

        nph = ph; nown = own; nbeats = beats; nlcmd = lcmd;
        if (!rst) begin
            case (ph)
                0: begin
                    p = -1;
                    if (e0 && e1) begin
`ifdef PSARB_ROUND_ROBIN_EN
                        p = (own == 0) ? 1 : 0;
`else
                        p = 0;
`endif
                    end else if (e0) p = 0;
                    else if (e1) p = 1;
                    if (p >= 0) begin
                        nph = 1; nown = p;
                        nlcmd = (p == 1) ? bus.m1_cmd : bus.m0_cmd;
                    end
                end
                1: begin
                    if (!eo) nph = 0;
                    else if (bus.psram_ready) begin
                        if (lcmd) begin nph = 2; nbeats = 1; end
                        else begin nph = 3; nbeats = 0; end
                    end
                end
                2: begin
                    nbeats = beats + 1;
                    if (nbeats == BW) nph = 0;
                end
                default: begin
                    if (bus.psram_rvalid) begin
                        nbeats = beats + 1;
                        if (nbeats == BW) nph = 0;
                    end
                end
            endcase
        end
        @(posedge clk);
        ph = nph; own = nown; beats = nbeats; lcmd = nlcmd;
        #1;
    endtask

    initial begin
        model_reset();
        clear_counts();
        idle_inputs();
        bus.m0_cmd = 1'b0; bus.m1_cmd = 1'b0;
        bus.m0_addr = 23'h7fffc0; bus.m1_addr = 23'h123440;
        bus.m0_wdata = 32'hdeadbeef; bus.m1_wdata = 32'hcafef00d;
        bus.m0_mask = 4'hf; bus.m1_mask = 4'ha;
        rst = 1'b1;

        // Reset state.
        step(); step();
        chk("rst_addr", 32'(bus.psram_addr), 32'd0);
        chk("rst_wdata", bus.psram_wdata, 32'd0);
        chk("rst_mask", 32'(bus.psram_mask), 32'd0);
        chk("rst_cmd", 32'(bus.psram_cmd), 32'd0);
        rst = 1'b0;
        step();

        // Master 0 read, ready three cycles after the request.
        clear_counts();
        bus.m0_cmd_en = 1'b1; bus.m0_cmd = 1'b0; bus.m0_addr = 23'h000040;
        step();
        step(); step();
        bus.psram_ready = 1'b1;
        step();
        bus.m0_cmd_en = 1'b0; bus.psram_ready = 1'b0;
        for (int i = 0; i < BW; i++) begin
            bus.psram_rvalid = 1'b1; bus.psram_rdata = 32'(i);
            step();
            if (i % 5 == 2) begin bus.psram_rvalid = 1'b0; step(); end
        end
        bus.psram_rvalid = 1'b0;
        step();
        chk("rd0_ready_pulses", 32'(ready_cnt[0]), 32'd1);
        chk("rd0_rvalid_beats", 32'(rvalid_cnt[0]), 32'd16);
        chk("rd0_m1_rvalid", 32'(rvalid_cnt[1]), 32'd0);
        chk("rd0_grant_end", 32'(bus.grant), 32'd0);

        // Master 1 write, ready on the first command cycle.
        clear_counts();
        bus.m1_cmd_en = 1'b1; bus.m1_cmd = 1'b1; bus.m1_addr = 23'h001000;
        bus.m1_wdata = $urandom; bus.m1_mask = 4'($urandom);
        step();
        bus.psram_ready = 1'b1;
        step();
        bus.m1_cmd_en = 1'b0; bus.psram_ready = 1'b0;
        for (int i = 0; i < BW + 2; i++) begin
            bus.m1_wdata = $urandom; bus.m1_mask = 4'($urandom);
            step();
        end
        chk("wr1_wbeats", 32'(wbeat_cnt[1]), 32'd16);
        chk("wr1_ready_pulses", 32'(ready_cnt[1]), 32'd1);
        chk("wr1_cmd_en_after", 32'(bus.psram_cmd_en), 32'd0);

        // Both masters request continuously.
        grant_log.delete();
        bus.m0_cmd_en = 1'b1; bus.m0_cmd = 1'b1;
        bus.m1_cmd_en = 1'b1; bus.m1_cmd = 1'b1;
        bus.psram_ready = 1'b1;
        for (int k = 0; k < 200 && grant_log.size() < 4; k++) step();
        idle_inputs();
        for (int k = 0; k < BW + 4; k++) step();
        chk("order_count", 32'(grant_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
`ifdef PSARB_ROUND_ROBIN_EN
            chk("order_owner", 32'(grant_log[i]), 32'(i % 2));
`else
            chk("order_owner", 32'(grant_log[i]), 32'd0);
`endif
        end

        // Owner withdraws during the command phase.
        clear_counts();
        bus.m0_cmd_en = 1'b1; bus.m0_cmd = 1'b1;
        step();
        step();
        bus.m0_cmd_en = 1'b0;
        step();
        chk("drop_busy", 32'(bus.busy), 32'd0);
        step();
        chk("drop_no_ready", 32'(ready_cnt[0]), 32'd0);

        // Stray read data while idle.
        bus.psram_rvalid = 1'b1; bus.psram_rdata = $urandom;
        step();
        chk("stray_err", 32'(bus.err_stray), 32'd1);
        chk("stray_rvalid", 32'({bus.m1_rvalid, bus.m0_rvalid}), 32'd0);
        bus.psram_rvalid = 1'b0;
        step();
        chk("stray_clear", 32'(bus.err_stray), 32'd0);

        // Reset in the middle of a read burst.
        bus.m0_cmd_en = 1'b1; bus.m0_cmd = 1'b0;
        step();
        bus.psram_ready = 1'b1;
        step();
        bus.m0_cmd_en = 1'b0; bus.psram_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.psram_rvalid = 1'b1; bus.psram_rdata = 32'(i);
            step();
        end
        bus.psram_rdata = 32'd7;
        #2;
        chk("mid_beat8", 32'(bus.m0_rvalid), 32'd1);
        rst = 1'b1; bus.psram_rvalid = 1'b0; bus.psram_rdata = 32'd0;
        #1;
        chk("mr_grant", 32'(bus.grant), 32'd0);
        chk("mr_busy", 32'(bus.busy), 32'd0);
        chk("mr_cmd_en", 32'(bus.psram_cmd_en), 32'd0);
        chk("mr_strobes", 32'({bus.m0_ready, bus.m1_ready, bus.m0_rvalid, bus.m1_rvalid,
                               bus.m0_wbeat, bus.m1_wbeat, bus.err_stray}), 32'd0);
        chk("mr_data", 32'(bus.psram_addr) | bus.psram_wdata | 32'(bus.psram_mask), 32'd0);
        step();
        rst = 1'b0;
        step();
        clear_counts();
        bus.m1_cmd_en = 1'b1; bus.m1_cmd = 1'b0; bus.m1_addr = 23'h002000;
        step();
        chk("post_rst_grant", 32'(bus.grant), 32'd2);
        bus.psram_ready = 1'b1;
        step();
        bus.m1_cmd_en = 1'b0; bus.psram_ready = 1'b0;
        for (int i = 0; i < BW; i++) begin
            bus.psram_rvalid = 1'b1; bus.psram_rdata = $urandom;
            step();
        end
        bus.psram_rvalid = 1'b0;
        step();
        chk("post_rst_rvalid", 32'(rvalid_cnt[1]), 32'd16);

        // Randomized traffic.
        for (int k = 0; k < 1500; k++) begin
            bus.m0_cmd_en = ($urandom_range(0, 3) != 0);
            bus.m1_cmd_en = ($urandom_range(0, 3) != 0);
            bus.m0_cmd = 1'($urandom); bus.m1_cmd = 1'($urandom);
            bus.m0_addr = 23'($urandom) & 23'h7fffc0;
            bus.m1_addr = 23'($urandom) & 23'h7fffc0;
            bus.m0_wdata = $urandom; bus.m1_wdata = $urandom;
            bus.m0_mask = 4'($urandom); bus.m1_mask = 4'($urandom);
            bus.psram_ready = 1'($urandom);
            bus.psram_rvalid = ($urandom_range(0, 9) < 6);
            bus.psram_rdata = $urandom;
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        idle_inputs();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/psram_cmd_arb.md
Name: psram_cmd_arb

Overview:
- Shares the single PSRAM command/data port between two burst masters on the psclk domain.
- Master 0 is the cache write-back/read-fill bridge; master 1 is a secondary master (DMA or instruction fetch).
- Grants one master at a time and holds ownership for a whole 64-byte burst.
- Steers write data, ready and read-valid per master so each master sees a private PSRAM port.

Parameters:
- BURST_WORDS, 16, 32-bit beats per burst (64 bytes).
- CNT_W, 4, beat counter width; 2**CNT_W must equal BURST_WORDS.

Ports:
- psclk  in  1  PSRAM-domain clock.
- PSRST  in  1  asynchronous reset, active-high.
- m0_cmd_en  in  1  master 0 request; held until m0_ready.
- m0_cmd  in  1  master 0 command, 1=write, 0=read.
- m0_addr  in  23  master 0 burst byte address, 64-byte aligned.
- m0_wdata  in  32  master 0 write beat.
- m0_mask  in  4  master 0 byte mask (1 = masked).
- m0_ready  out  1  master 0 command accepted.
- m0_rvalid  out  1  master 0 read beat valid.
- m0_wbeat  out  1  master 0 write beat consumed; master advances its data.
- m1_cmd_en, m1_cmd, m1_addr, m1_wdata, m1_mask, m1_ready, m1_rvalid, m1_wbeat: same as master 0.
- m_rdata  out  32  psram_rdata broadcast to both masters.
- psram_cmd  out  1  to PSRAM controller.
- psram_cmd_en  out  1  to PSRAM controller.
- psram_addr  out  23  to PSRAM controller.
- psram_wdata  out  32  to PSRAM controller.
- psram_mask  out  4  to PSRAM controller.
- psram_ready  in  1  command accept from PSRAM controller.
- psram_rvalid  in  1  read beat from PSRAM controller.
- psram_rdata  in  32  read data from PSRAM controller.
- grant  out  2  one-hot current owner; 00 when idle.
- busy  out  1  state != IDLE.
- err_stray  out  1  one-cycle pulse on psram_rvalid while no read is outstanding.

Behaviour:
- Reset values: state IDLE, grant 00, beat counter 0, all outputs 0, including psram_cmd_en, m*_ready, m*_rvalid, m*_wbeat and err_stray.
- States: IDLE, CMD, WDAT, RDAT.
- IDLE:
  - If any m*_cmd_en is high, register grant, latch the owner's cmd into cur_cmd, and go to CMD.
  - Selection is fixed priority, master 0 first (see Optional Feature).
- CMD:
  - psram_cmd_en, psram_cmd, psram_addr, psram_wdata and psram_mask are muxed combinationally from the owner.
  - psram_cmd_en = owner cmd_en.
  - Latency: request sampled in cycle t, psram_cmd_en high in t+1.
  - When psram_ready and owner cmd_en are both high: pulse owner m_ready; go to WDAT if cur_cmd=1, else RDAT.
  - Write: beat 0 is transferred in the accept cycle, so the owner's m_wbeat pulses with m_ready and the counter loads 1.
  - Read: the counter loads 0.
  - If the owner drops cmd_en before psram_ready: return to IDLE and clear grant. No command is issued, since cmd_en is gated.
- WDAT:
  - m_wbeat is high every cycle; psram_wdata and psram_mask come from the owner; the counter increments.
  - When the counter reaches BURST_WORDS-1: go to IDLE next cycle and clear the counter.
  - Total: exactly BURST_WORDS beats, on consecutive cycles starting at accept.
- RDAT:
  - Each psram_rvalid: pulse the owner's m_rvalid in the same cycle (combinational) and increment the counter.
  - On the rvalid where the counter is BURST_WORDS-1: go to IDLE.
  - Non-owner m_rvalid stays 0.
- psram_rvalid in IDLE, CMD or WDAT: pulse err_stray; no m_rvalid.
- Outside CMD and WDAT: psram_cmd_en=0; psram_addr, psram_wdata and psram_mask hold the muxed value of the last owner (don't-care).
- Back-to-back: one IDLE cycle always separates bursts (arbitration turnaround); a waiting master is granted in that cycle.
- Requests from the non-owner are ignored until IDLE; they are not queued.
- Reset mid-burst: immediate return to IDLE. PSRAM-side recovery belongs to the PSRAM controller's own reset (same PSRST).

Optional Feature:
- Macro PSARB_ROUND_ROBIN_EN.
- Defined: a last_owner flop (reset = master 1, so master 0 wins first). When both masters request in IDLE, the master that was not last_owner is granted. last_owner updates on every grant.
- Undefined: fixed priority, master 0 always wins ties.

Decomposition:
- Shared package psram_arb_pkg:
  - state encoding localparams (IDLE=2'd0, CMD=2'd1, WDAT=2'd2, RDAT=2'd3);
  - PS_CMD_WRITE=1'b1 / PS_CMD_READ=1'b0;
  - PS_ADDR_W=23, PS_DATA_W=32.
- One sub-module, psram_arb_pick: a combinational two-request picker taking req[1:0] and last_owner, producing one-hot pick. It isolates the macro-dependent policy.

Test Plan:
- Master 0 read: m0_cmd_en with addr 0x000040; psram_ready 3 cycles later; 16 rvalid pulses with data 0..15 → m0_ready single pulse, m0_rvalid ×16, m1_rvalid 0, grant 01→00 after the 16th beat.
- Master 1 write: m1 cmd=1, addr 0x001000, ready on the first CMD cycle → m1_wbeat high 16 consecutive cycles starting at accept; psram_wdata equals m1_wdata each cycle; psram_cmd_en low afterwards.
- Simultaneous requests held continuously, two bursts each:
  - without macro, order is m0, m0 (m1 starved while m0 re-requests);
  - with PSARB_ROUND_ROBIN_EN, order is m0, m1, m0, m1.
- Owner drops m0_cmd_en in CMD before ready → psram_cmd_en falls the same cycle, state IDLE next cycle, no m0_ready.
- psram_rvalid while idle → err_stray one-cycle pulse, no m*_rvalid.
- Assert PSRST during the 8th read beat → all outputs 0 and grant 00; after release, a new m1 request is granted normally.
